// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver with a byte-to-word deserializer (first byte is the word's MSB).
// Each completed word is presented as a one-cycle write strobe for a downstream fifo.
module uart_rx_deser #(
  parameter int OUT_W        = 24,
  parameter int CK_PER_BIT   = 869,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  output logic [OUT_W-1:0] data_out,
  output logic             data_out_val,
  output logic             frame_err,
  output logic             rx_busy
);

  localparam int BYTES_PER_WORD = (OUT_W + 7) / 8;
  localparam int CW             = (CK_PER_BIT > 1) ? $clog2(CK_PER_BIT) : 1;
  localparam int TO_CYCLES      = TIMEOUT_BITS * CK_PER_BIT;
  localparam int TW             = $clog2(TO_CYCLES + 1);
  localparam int BCW            = $clog2(BYTES_PER_WORD + 1);

  localparam logic [CW-1:0]  HALF    = CW'(CK_PER_BIT / 2);
  localparam logic [CW-1:0]  LAST    = CW'(CK_PER_BIT - 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TO_CYCLES - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_next;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic [BCW-1:0]   byte_cnt;
  logic [TW-1:0]    idle_tmr;
  logic [OUT_W-1:0] asm_next;

  logic start_det;
  logic cnt_clr;
  logic shift_en;
  logic accept;
  logic stop_bad;

  // Synchronizer presets to 1 so reset looks like an idle line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_in};
  end

  assign rx_s    = sync_q[1];
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Sampling points: mid start bit, then every full bit period from there.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    accept     = 1'b0;
    stop_bad   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          start_det  = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          state_next = IDLE;
          accept     = rx_s;
          stop_bad   = !rx_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt <= '0;
    else if (cnt_clr || cnt == LAST) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  // Old partial-word bits never need clearing: a full word shifts them all out.
  generate
    if (OUT_W > 8) begin : g_asm
      logic [OUT_W-9:0] asm_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       asm_q <= '0;
        else if (accept) asm_q <= asm_next[OUT_W-9:0];
      end
      assign asm_next = {asm_q, shift_q};
    end else begin : g_byte
      assign asm_next = shift_q[OUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx      <= '0;
      shift_q      <= '0;
      byte_cnt     <= '0;
      idle_tmr     <= '0;
      data_out     <= '0;
      data_out_val <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      data_out_val <= 1'b0;
      frame_err    <= 1'b0;

      if (start_det) bit_idx <= '0;
      else if (shift_en) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      // Long idle inside a word means the host gave up; realign to a word boundary.
      if (start_det) idle_tmr <= '0;
      else if (state == IDLE && byte_cnt != '0) begin
        if (idle_tmr == TO_LAST) begin
          idle_tmr <= '0;
          byte_cnt <= '0;
        end else begin
          idle_tmr <= idle_tmr + 1'b1;
        end
      end

      if (stop_bad) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
      end else if (accept) begin
        if (byte_cnt == BC_LAST) begin
          data_out     <= asm_next;
          data_out_val <= 1'b1;
          byte_cnt     <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: a bit-queue line driver, a pulse monitor, table vectors,
// hand-written corner sequences and random streams checked against a word-level model.
module tb_uart_rx_deser;

  localparam int CK    = 16;
  localparam int OUT_W = 24;
  localparam int TOB   = 4;
  localparam int DRAIN_LIMIT = 60000;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             rx_in = 1'b1;
  logic [OUT_W-1:0] data_out;
  logic             data_out_val;
  logic             frame_err;
  logic             rx_busy;

  uart_rx_deser #(.OUT_W(OUT_W), .CK_PER_BIT(CK), .TIMEOUT_BITS(TOB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .data_out    (data_out),
    .data_out_val(data_out_val),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Line driver state: main pushes bits, the driver alone pops them.
  logic bitq[$];
  int   flush_epoch = 0;
  int   seen_epoch  = 0;
  int   bits_sent   = 0;
  logic glitch      = 1'b0;

  initial begin
    int   tick    = 0;
    logic cur_bit = 1'b1;
    forever begin
      @(negedge clk);
      if (flush_epoch != seen_epoch) begin
        seen_epoch = flush_epoch;
        bitq.delete();
        cur_bit = 1'b1;
        tick    = 0;
      end
      if (tick == 0) begin
        if (bitq.size() > 0) begin
          cur_bit = bitq.pop_front();
          bits_sent++;
        end else begin
          cur_bit = 1'b1;
        end
      end
      rx_in = glitch ? 1'b0 : cur_bit;
      tick  = (tick == CK - 1) ? 0 : tick + 1;
    end
  end

  // Monitor: counts strobes, collects words, tracks rx_busy windows.
  int   val_cnt = 0, ferr_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int   busy_len = 0, last_busy_len = 0;
  logic prev_busy = 1'b0, fall_with_val = 1'b0;
  logic both_seen = 1'b0, val_off_fall = 1'b0;
  logic [OUT_W-1:0] obs_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        busy_len  = 0;
      end else begin
        if (data_out_val) begin
          val_cnt++;
          obs_q.push_back(data_out);
          if (!(prev_busy && !rx_busy)) val_off_fall = 1'b1;
        end
        if (frame_err) ferr_cnt++;
        if (data_out_val && frame_err) both_seen = 1'b1;
        if (rx_busy && !prev_busy) rise_cnt++;
        if (rx_busy) busy_len++;
        if (!rx_busy && prev_busy) begin
          fall_cnt++;
          last_busy_len = busy_len;
          busy_len      = 0;
          fall_with_val = data_out_val;
        end
        prev_busy = rx_busy;
      end
    end
  end

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [2:0]  stop_ok;
    int          gap_bits;
    int          exp_vals;
    int          exp_ferrs;
    logic [23:0] exp_word;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       ok;
    int         gap;
  } fr_t;

  vec_t             vecs[7];
  fr_t              fr_q[$];
  logic [OUT_W-1:0] exp_q[$];
  int               exp_ferrs;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    vectors++;
    if (actual < lo || actual > hi) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // A bad stop bit is followed by one idle bit so the next start edge is real.
  task automatic push_frame(input logic [7:0] b, input logic stop_ok);
    bitq.push_back(1'b0);
    for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
    bitq.push_back(stop_ok);
    if (!stop_ok) bitq.push_back(1'b1);
  endtask

  task automatic push_idle(input int nbits);
    for (int i = 0; i < nbits; i++) bitq.push_back(1'b1);
  endtask

  task automatic wait_tx_done();
    int guard = 0;
    while (bitq.size() != 0 && guard < DRAIN_LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= DRAIN_LIMIT) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL tx_drain: got %0d bits pending, expected 0", bitq.size());
    end
    repeat (2 * CK) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    push_frame(v.b0, v.stop_ok[0]);
    push_idle(v.gap_bits);
    push_frame(v.b1, v.stop_ok[1]);
    push_frame(v.b2, v.stop_ok[2]);
    push_idle(8);
    wait_tx_done();
  endtask

  // Word-level reference: long gaps and bad stop bits drop the partial word.
  task automatic run_model();
    logic [7:0] part[$];
    exp_q.delete();
    exp_ferrs = 0;
    foreach (fr_q[i]) begin
      if (fr_q[i].gap >= 6) part.delete();
      if (!fr_q[i].ok) begin
        exp_ferrs++;
        part.delete();
      end else begin
        part.push_back(fr_q[i].b);
        if (part.size() == 3) begin
          exp_q.push_back({part[0], part[1], part[2]});
          part.delete();
        end
      end
    end
  endtask

  task automatic run_random(input string tag);
    int v0 = val_cnt;
    int f0 = ferr_cnt;
    int o0 = obs_q.size();
    int n;
    run_model();
    foreach (fr_q[i]) begin
      push_idle(fr_q[i].gap);
      push_frame(fr_q[i].b, fr_q[i].ok);
    end
    push_idle(8);
    wait_tx_done();
    checkOutput({tag, "_words"}, 32'(val_cnt - v0), 32'(exp_q.size()));
    checkOutput({tag, "_ferrs"}, 32'(ferr_cnt - f0), 32'(exp_ferrs));
    n = (obs_q.size() - o0 < exp_q.size()) ? obs_q.size() - o0 : exp_q.size();
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s_word%0d", tag, k), 32'(obs_q[o0 + k]), 32'(exp_q[k]));
  endtask

  initial begin
    int v0, f0, r0, d0, base, guard;

    vecs[0] = '{8'h12, 8'hAB, 8'h34, 3'b111, 0, 1, 0, 24'h12AB34};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 3'b111, 0, 1, 0, 24'h000000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 3'b111, 0, 1, 0, 24'hFFFFFF};
    vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 3'b011, 0, 0, 1, 24'hFFFFFF};
    vecs[4] = '{8'h55, 8'h66, 8'h77, 3'b111, 6, 0, 0, 24'hFFFFFF};
    vecs[5] = '{8'h80, 8'h01, 8'h7E, 3'b111, 2, 1, 0, 24'h80017E};
    vecs[6] = '{8'h11, 8'h22, 8'h33, 3'b110, 0, 0, 1, 24'h80017E};

    repeat (3) @(negedge clk);
    checkOutput("reset_data_out", 32'(data_out), 32'h0);
    checkOutput("reset_val", 32'(data_out_val), 32'h0);
    checkOutput("reset_ferr", 32'(frame_err), 32'h0);
    checkOutput("reset_busy", 32'(rx_busy), 32'h0);
    reset = 1'b0;
    push_idle(2);
    wait_tx_done();

    $display("[TB] back-to-back word with strobe timing");
    v0 = val_cnt; f0 = ferr_cnt;
    push_frame(8'h12, 1'b1);
    push_frame(8'hAB, 1'b1);
    push_frame(8'h34, 1'b1);
    wait_tx_done();
    checkOutput("t1_vals", 32'(val_cnt - v0), 32'd1);
    checkOutput("t1_ferrs", 32'(ferr_cnt - f0), 32'd0);
    checkOutput("t1_word", 32'(data_out), 32'h12AB34);
    checkOutput("t1_val_at_busy_fall", 32'(fall_with_val), 32'd1);
    checkRange("t1_busy_len", last_busy_len, 9 * CK + CK / 2 - 2, 9 * CK + CK / 2 + 2);

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) begin
      v0 = val_cnt; f0 = ferr_cnt;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_vals", i), 32'(val_cnt - v0), 32'(vecs[i].exp_vals));
      checkOutput($sformatf("vec%0d_ferrs", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferrs));
      checkOutput($sformatf("vec%0d_word", i), 32'(data_out), 32'(vecs[i].exp_word));
    end

    $display("[TB] start-bit glitch");
    v0 = val_cnt; f0 = ferr_cnt; r0 = rise_cnt; d0 = fall_cnt;
    glitch = 1'b1;
    repeat (5) @(negedge clk);
    glitch = 1'b0;
    repeat (2 * CK) @(negedge clk);
    checkOutput("t2_busy_rise", 32'(rise_cnt - r0), 32'd1);
    checkOutput("t2_busy_fall", 32'(fall_cnt - d0), 32'd1);
    checkOutput("t2_vals", 32'(val_cnt - v0), 32'd0);
    checkOutput("t2_ferrs", 32'(ferr_cnt - f0), 32'd0);

    $display("[TB] bad stop bit discards partial word");
    v0 = val_cnt; f0 = ferr_cnt;
    push_frame(8'h01, 1'b1);
    push_frame(8'h02, 1'b0);
    push_frame(8'hAA, 1'b1);
    push_frame(8'hBB, 1'b1);
    push_frame(8'hCC, 1'b1);
    wait_tx_done();
    checkOutput("t3_ferrs", 32'(ferr_cnt - f0), 32'd1);
    checkOutput("t3_vals", 32'(val_cnt - v0), 32'd1);
    checkOutput("t3_word", 32'(data_out), 32'hAABBCC);

    $display("[TB] inter-byte timeout");
    v0 = val_cnt;
    push_frame(8'h55, 1'b1);
    push_frame(8'h66, 1'b1);
    push_idle(5);
    push_frame(8'h77, 1'b1);
    push_frame(8'h88, 1'b1);
    push_frame(8'h99, 1'b1);
    wait_tx_done();
    checkOutput("t4_vals", 32'(val_cnt - v0), 32'd1);
    checkOutput("t4_word", 32'(data_out), 32'h778899);

    $display("[TB] reset in the middle of a word");
    base = bits_sent;
    push_frame(8'h3C, 1'b1);
    push_frame(8'hC3, 1'b1);
    guard = 0;
    while (bits_sent < base + 16 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL t5_wait_bit4: got %0d bits sent, expected %0d", bits_sent - base, 16);
    end
    repeat (CK / 2) @(negedge clk);
    reset = 1'b1;
    flush_epoch++;
    repeat (2) @(negedge clk);
    checkOutput("t5_rst_data_out", 32'(data_out), 32'h0);
    checkOutput("t5_rst_val", 32'(data_out_val), 32'h0);
    checkOutput("t5_rst_ferr", 32'(frame_err), 32'h0);
    checkOutput("t5_rst_busy", 32'(rx_busy), 32'h0);
    reset = 1'b0;
    v0 = val_cnt; f0 = ferr_cnt;
    push_idle(2);
    push_frame(8'hDE, 1'b1);
    push_frame(8'hAD, 1'b1);
    push_frame(8'hBE, 1'b1);
    wait_tx_done();
    checkOutput("t5_vals", 32'(val_cnt - v0), 32'd1);
    checkOutput("t5_ferrs", 32'(ferr_cnt - f0), 32'd0);
    checkOutput("t5_word", 32'(data_out), 32'hDEADBE);

    $display("[TB] random back-to-back stream of 100 words");
    fr_q.delete();
    for (int i = 0; i < 300; i++) fr_q.push_back('{8'($urandom_range(0, 255)), 1'b1, 0});
    run_random("rand100");

    $display("[TB] random stream with gaps and bad stop bits");
    fr_q.delete();
    for (int i = 0; i < 40; i++) begin
      int   r  = $urandom_range(0, 9);
      int   g  = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 2) : $urandom_range(6, 8);
      logic ok = ($urandom_range(0, 9) != 0);
      fr_q.push_back('{8'($urandom_range(0, 255)), ok, g});
    end
    run_random("mixed");

    checkOutput("val_ferr_same_cycle", 32'(both_seen), 32'd0);
    checkOutput("val_at_stop_sample", 32'(val_off_fall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
